rx_slip_ctrl: RTL and testbench



---
 rtl/rx_slip_ctrl.sv | 148 ++++++++++++++
 tb/tb_rx_slip_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/rx_slip_ctrl.sv
// 66b block-alignment slip sequencer for the 10GBASE-R RX path.
// Define RX_SLIP_CTRL_STATS_EN to add slip/escalation statistics outputs.
module rx_slip_ctrl #(
  parameter int SETTLE_CYCLES = 32,
  parameter int MAX_SLIPS     = 66,
  parameter int RESET_CYCLES  = 16,
  localparam int CNT_W = $clog2(MAX_SLIPS + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  input  logic             i_slip_req,
  input  logic             i_block_lock,
  output logic             o_gearbox_slip,
  output logic             o_lock_reset,
  output logic             o_aligned,
  output logic [CNT_W-1:0] o_slip_count,
  output logic             o_rx_reset_req
`ifdef RX_SLIP_CTRL_STATS_EN
  ,
  output logic [31:0]      o_slip_total,
  output logic [15:0]      o_escalate_total
`endif
);

  localparam int TMR_MAX =
    (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] SET_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_SLIPS - 1);

  typedef enum logic [2:0] {
    SEARCH   = 3'd0,
    SLIP     = 3'd1,
    SETTLE   = 3'd2,
    LOCKED   = 3'd3,
    ESCALATE = 3'd4
  } state_e;

  state_e state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic slip_q, slip_d;
  logic lrst_q, lrst_d;
  logic algn_q, algn_d;
  logic rreq_q, rreq_d;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      SEARCH: begin
        if (i_valid) begin
          if (i_slip_req) begin
            state_d = (cnt_q == CNT_LAST) ? ESCALATE : SLIP;
          end else if (i_block_lock) begin
            state_d = LOCKED;
          end
        end
      end
      SLIP: state_d = SETTLE;
      SETTLE: begin
        if (i_valid) begin
          if (tmr_q == SET_LAST) state_d = SEARCH;
          else tmr_d = tmr_q + 1'b1;
        end
      end
      LOCKED: begin
        if (i_valid) begin
          if (i_slip_req) state_d = SLIP;
          else if (!i_block_lock) state_d = SEARCH;
        end
      end
      ESCALATE: begin
        if (tmr_q == RST_LAST) state_d = SETTLE;
        else tmr_d = tmr_q + 1'b1;
      end
      default: state_d = SEARCH;
    endcase

    // timer restarts on every state change
    if (state_d != state_q) tmr_d = '0;

    if (state_d == SLIP) cnt_d = cnt_q + 1'b1;
    if (state_d == LOCKED && state_q != LOCKED) cnt_d = '0;
    if (state_q == ESCALATE && state_d == SETTLE) cnt_d = '0;

    slip_d = (state_d == SLIP);
    lrst_d = (state_d == SETTLE) || (state_d == ESCALATE);
    algn_d = (state_d == LOCKED);
    rreq_d = (state_d == ESCALATE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= SEARCH;
      tmr_q   <= '0;
      cnt_q   <= '0;
      slip_q  <= 1'b0;
      lrst_q  <= 1'b0;
      algn_q  <= 1'b0;
      rreq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      slip_q  <= slip_d;
      lrst_q  <= lrst_d;
      algn_q  <= algn_d;
      rreq_q  <= rreq_d;
    end
  end

  assign o_gearbox_slip = slip_q;
  assign o_lock_reset   = lrst_q;
  assign o_aligned      = algn_q;
  assign o_slip_count   = cnt_q;
  assign o_rx_reset_req = rreq_q;

`ifdef RX_SLIP_CTRL_STATS_EN
  logic [31:0] stot_q, stot_d;
  logic [15:0] etot_q, etot_d;

  always_comb begin
    stot_d = stot_q;
    etot_d = etot_q;
    if (slip_d && (stot_q != '1)) stot_d = stot_q + 1'b1;
    if (rreq_d && !rreq_q && (etot_q != '1)) etot_d = etot_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stot_q <= '0;
      etot_q <= '0;
    end else begin
      stot_q <= stot_d;
      etot_q <= etot_d;
    end
  end

  assign o_slip_total     = stot_q;
  assign o_escalate_total = etot_q;
`endif

endmodule

// File: tb/tb_rx_slip_ctrl.sv
// Directed self-checking bench for rx_slip_ctrl.
// Default parameters: SETTLE 32, MAX_SLIPS 66, RESET 16.
module tb_rx_slip_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid = 1'b0;
  logic slip_req = 1'b0;
  logic lock = 1'b0;
  logic gs, lrst, aligned, rreq;
  logic [6:0] cnt;
`ifdef RX_SLIP_CTRL_STATS_EN
  logic [31:0] stot;
  logic [15:0] etot;
`endif

  int vecs = 0;
  int errs = 0;
  int np = 0;

  always #5 clk = ~clk;

  rx_slip_ctrl dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_valid        (valid),
    .i_slip_req     (slip_req),
    .i_block_lock   (lock),
    .o_gearbox_slip (gs),
    .o_lock_reset   (lrst),
    .o_aligned      (aligned),
    .o_slip_count   (cnt),
    .o_rx_reset_req (rreq)
`ifdef RX_SLIP_CTRL_STATS_EN
    ,
    .o_slip_total     (stot),
    .o_escalate_total (etot)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (gs) np++;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gs"}, int'(gs), 0);
    chk({tag, "_lrst"}, int'(lrst), 0);
    chk({tag, "_algn"}, int'(aligned), 0);
    chk({tag, "_cnt"}, int'(cnt), 0);
    chk({tag, "_rreq"}, int'(rreq), 0);
  endtask

  initial begin
    int p0, p1, n, mx, seen;

    #12;
    chk_zero("rst");

    // lock on cycle 3 after release
    tick;
    rst_n = 1'b1;
    valid = 1'b1;
    p0 = np;
    tick;
    tick;
    chk("pre_lock_algn", int'(aligned), 0);
    lock = 1'b1;
    tick;
    chk("lock_algn", int'(aligned), 1);
    chk("lock_cnt", int'(cnt), 0);
    tick;
    chk("lock_np", np - p0, 0);

    // slip from LOCKED with lock lost on the same valid
    p0 = np;
    slip_req = 1'b1;
    lock = 1'b0;
    tick;
    slip_req = 1'b0;
    chk("lk_slip_gs", int'(gs), 1);
    chk("lk_slip_algn", int'(aligned), 0);
    chk("lk_slip_cnt", int'(cnt), 1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (!lrst) break;
      n++;
    end
    chk("settle_len", n, 32);
    chk("lk_slip_np", np - p0, 1);

    // slip from SEARCH; valid toggles in SETTLE, requests held
    p0 = np;
    slip_req = 1'b1;
    tick;
    chk("srch_slip_gs", int'(gs), 1);
    chk("srch_slip_cnt", int'(cnt), 2);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      valid = (i % 2 == 0);
      tick;
      if (!lrst) break;
      n++;
    end
    slip_req = 1'b0;
    valid = 1'b1;
    chk("toggle_len", n, 64);
    chk("toggle_np", np - p0, 1);
    chk("toggle_cnt", int'(cnt), 2);

    // asynchronous reset mid-SETTLE
    slip_req = 1'b1;
    tick;
    slip_req = 1'b0;
    repeat (5) tick;
    chk("mid_settle_lrst", int'(lrst), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_settle");
    tick;
    rst_n = 1'b1;
    tick;
    chk_zero("post_rst_settle");

    // full sweep without lock escalates
    p0 = np;
    slip_req = 1'b1;
    mx = 0;
    seen = 0;
    for (int i = 0; i < 5000; i++) begin
      tick;
      if (int'(cnt) > mx) mx = int'(cnt);
      if (rreq) begin
        seen = 1;
        break;
      end
    end
    chk("esc_seen", seen, 1);
    chk("esc_pulses", np - p0, 65);
    chk("esc_max_cnt", mx, 65);
    chk("esc_cnt_hold", int'(cnt), 65);
    chk("esc_lrst", int'(lrst), 1);
    p1 = np;
    n = 1;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (!rreq) break;
      n++;
    end
    chk("esc_len", n, 16);
    chk("esc_np", np - p1, 0);
    chk("esc_exit_cnt", int'(cnt), 0);
    chk("esc_exit_lrst", int'(lrst), 1);
`ifdef RX_SLIP_CTRL_STATS_EN
    chk("stat_slips", int'(stot), 65);
    chk("stat_esc", int'(etot), 1);
`endif

    // asynchronous reset mid-ESCALATE
    seen = 0;
    for (int i = 0; i < 5000; i++) begin
      tick;
      if (rreq) begin
        seen = 1;
        break;
      end
    end
    chk("esc2_seen", seen, 1);
    repeat (5) tick;
    chk("mid_esc_rreq", int'(rreq), 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_esc");
    tick;
    rst_n = 1'b1;
    slip_req = 1'b0;
    tick;
    chk_zero("post_rst_esc");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
